// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_pkg
// Description : Shared constants and types for the cache miss-fill logic.
//               Holds the block geometry and the fill controller state type.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_pkg;

    // Block geometry: one block is BLOCK_BYTES bytes made of WORDS 16-bit words.
    localparam int BLOCK_BYTES = 16;
    localparam int WORDS       = 8;
    localparam int OFFSET_BITS = 4;

    // Fill controller states: waiting for a miss, or streaming a block in.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_t;

endpackage
`default_nettype wire

// File: rtl/fill_counter.sv
`default_nettype none
// ============================================================================
// Module      : fill_counter
// Description : Word counter for one side (issue or receive) of a block fill.
//               Synchronous clear, increments on request, saturates at LIMIT
//               and flags when LIMIT has been reached. The counter is one bit
//               wider than the word index so that "all words done" is distinct
//               from "last word in flight".
// Revision    : 1.0 - initial release
// ============================================================================
module fill_counter
    import cache_pkg::*;
#(
    parameter int LIMIT = WORDS,
    parameter int IDX_W = $clog2(LIMIT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [IDX_W-1:0] count,
    output logic             done
);

    localparam logic [IDX_W:0] c_limit = LIMIT[IDX_W:0];

    logic [IDX_W:0] r_cnt;

    // Count state: clear wins over increment; increments stop at the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != c_limit)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign count = r_cnt[IDX_W-1:0];
    assign done  = (r_cnt == c_limit);

endmodule
`default_nettype wire

// File: rtl/cache_fill_fsm.sv
`default_nettype none
// ============================================================================
// Module      : cache_fill_fsm
// Description : Cache miss-fill controller. On a miss it stalls the pipeline,
//               issues WORDS back-to-back word reads to main memory, writes
//               each returned word into the cache data array and commits the
//               tag together with the final word. Responses are counted, not
//               timed, so any memory latency and gaps in the valid stream are
//               tolerated.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_fill_fsm
    import cache_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int WORDS  = cache_pkg::WORDS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    input  logic [DATA_W-1:0] memory_data,
    input  logic              memory_data_valid,
    output logic              fsm_busy,
    output logic              mem_enable,
    output logic [ADDR_W-1:0] memory_address,
    output logic              write_data_array,
    output logic [ADDR_W-1:0] fill_address,
    output logic [DATA_W-1:0] fill_data,
    output logic              write_tag_array
);

    // Word index width and byte-offset width within one block (2 bytes/word).
    localparam int                 c_idx_w    = $clog2(WORDS);
    localparam int                 c_off_w    = c_idx_w + 1;
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(WORDS - 1);

    fill_state_t       r_state;
    fill_state_t       w_state_nxt;
    logic [ADDR_W-1:0] r_base;

    logic              w_clr;
    logic              w_issue_inc;
    logic [c_idx_w-1:0] w_issue_idx;
    logic              w_issue_done;
    logic [c_idx_w-1:0] w_recv_idx;
    logic              w_recv_done;

    logic              w_busy;
    logic              w_mem_en;
    logic              w_wr;
    logic              w_tag;
    logic [ADDR_W-1:0] w_issue_addr;
    logic [ADDR_W-1:0] w_recv_addr;

    // State register: reset forces IDLE so any in-flight fill is abandoned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Block base: the miss address with the in-block byte offset cleared,
    // captured only when a miss is accepted so later address changes are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_base <= '0;
        end else if ((r_state == IDLE) && miss_detected) begin
            r_base <= {miss_address[ADDR_W-1:c_off_w], {c_off_w{1'b0}}};
        end
    end

    // Next-state and raw control outputs; the tag commit rides on the last word.
    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_mem_en    = 1'b0;
        w_wr        = 1'b0;
        w_tag       = 1'b0;
        w_clr       = 1'b0;
        case (r_state)
            IDLE: begin
                // Stall in the miss cycle itself; stray memory valids are ignored.
                w_busy = miss_detected;
                if (miss_detected) begin
                    w_clr       = 1'b1;
                    w_state_nxt = FILL;
                end
            end
            FILL: begin
                w_busy   = 1'b1;
                w_mem_en = !w_issue_done;
                if (memory_data_valid && !w_recv_done) begin
                    w_wr = 1'b1;
                    if (w_recv_idx == c_last_idx) begin
                        w_tag       = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_issue_inc = (r_state == FILL);

    // Request side: steps once per FILL cycle until every word has been asked for.
    fill_counter #(
        .LIMIT (WORDS),
        .IDX_W (c_idx_w)
    ) u_issue_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_clr),
        .inc   (w_issue_inc),
        .count (w_issue_idx),
        .done  (w_issue_done)
    );

    // Response side: steps once per accepted memory word, regardless of timing.
    fill_counter #(
        .LIMIT (WORDS),
        .IDX_W (c_idx_w)
    ) u_recv_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_clr),
        .inc   (w_wr),
        .count (w_recv_idx),
        .done  (w_recv_done)
    );

    // Word offsets are OR'd into the aligned base so they can never carry
    // into the tag bits; a block at the top of memory therefore cannot wrap.
    assign w_issue_addr = r_base | {{(ADDR_W - c_off_w){1'b0}}, w_issue_idx, 1'b0};
    assign w_recv_addr  = r_base | {{(ADDR_W - c_off_w){1'b0}}, w_recv_idx, 1'b0};

    // Outputs are additionally gated by rst_n so they drop to zero the moment
    // reset asserts, even while miss_detected or memory_data toggle.
    assign fsm_busy         = rst_n & w_busy;
    assign mem_enable       = rst_n & w_mem_en;
    assign write_data_array = rst_n & w_wr;
    assign write_tag_array  = rst_n & w_tag;
    assign memory_address   = mem_enable       ? w_issue_addr : '0;
    assign fill_address     = write_data_array ? w_recv_addr  : '0;
    assign fill_data        = write_data_array ? memory_data  : '0;

endmodule
`default_nettype wire

// File: doc/cache_fill_fsm.md
# cache_fill_fsm

Miss-handling controller sitting between the pipeline's instruction/data cache and multi-cycle main memory. On a cache miss, it stalls the pipeline and streams one 16-byte block (eight 16-bit words) from memory. As each word returns, it writes it into the cache data array, and it writes the tag array together with the final word. One instance serves the I-cache and one serves the D-cache; the pipeline holds PC and the pipeline registers while `fsm_busy` is high.

## Interface

Parameters:
- `ADDR_W`, 16: address width, in bytes.
- `DATA_W`, 16: word width.
- `WORDS`, 8: words per block. Block size is `WORDS*2` bytes and is a power of two.

Ports:
- `clk`  in  1: clock. Single clock domain.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `miss_detected`  in  1: cache lookup missed this cycle.
- `miss_address`  in  ADDR_W: byte address of the missing access.
- `memory_data`  in  DATA_W: word returned by main memory.
- `memory_data_valid`  in  1: `memory_data` is valid this cycle.
- `fsm_busy`  out  1: fill in progress; the pipeline stalls.
- `mem_enable`  out  1: read request to main memory this cycle.
- `memory_address`  out  ADDR_W: byte address of the request.
- `write_data_array`  out  1: write `fill_data` at `fill_address`.
- `fill_address`  out  ADDR_W: byte address of the returned word.
- `fill_data`  out  DATA_W: equals `memory_data`.
- `write_tag_array`  out  1: commit the tag and valid bit for `fill_address`'s block.

## Operation

- States are IDLE and FILL. The state and all counters are flops; every output is 0 in reset.
- **IDLE**
  - `fsm_busy = miss_detected`, combinational, so the pipeline stalls in the miss cycle itself.
  - On `miss_detected`: latch `base = miss_address` with the low `log2(WORDS*2)` bits cleared, clear `issue_cnt` and `recv_cnt`, and go to FILL.
  - `memory_data_valid` is ignored in IDLE: no writes occur.
- **FILL**
  - `fsm_busy = 1`.
  - Issue side, while `issue_cnt < WORDS`:
    - `mem_enable = 1`.
    - `memory_address = base + 2*issue_cnt`.
    - `issue_cnt` increments every cycle. It is `log2(WORDS)+1` bits wide and saturates at `WORDS`.
  - Receive side, on `memory_data_valid`:
    - `write_data_array = 1`.
    - `fill_address = base + 2*recv_cnt`.
    - `fill_data = memory_data`.
    - `recv_cnt` increments.
  - When `recv_cnt == WORDS-1` and `memory_data_valid`, assert `write_tag_array = 1` in that same cycle, then go to IDLE.
  - `miss_detected` is ignored in FILL. The requesting access re-looks-up after the stall and hits.
- Address arithmetic:
  - The word offset is OR'd into the aligned base, so it never carries into the tag bits.
  - `base + 2*(WORDS-1)` never wraps. For example, `0xFFF0..0xFFFE` is a legal block.
- Responses are counted, not timed, so any memory latency is tolerated, and so are gaps in the valid stream.
- Reset mid-fill:
  - Outputs drop to 0 immediately (asynchronous), the state goes to IDLE, and the counters clear.
  - Responses still in flight arrive in IDLE and are ignored.
  - No partial tag write ever occurs.
- Outputs not named as asserted in a state are 0. `fill_address` is don't-care when `write_data_array = 0`.

## Timing

- Miss seen in IDLE at cycle 0 → FILL from cycle 1.
- Requests go out in cycles 1..8, back-to-back.
- With a memory latency of L, data returns in cycles 1+L .. 8+L. `write_tag_array` asserts in cycle 8+L.
- `fsm_busy` is high in cycles 0..8+L and low in cycle 9+L. A fill with L=4 costs 13 stall cycles.
- There is a minimum of one IDLE cycle between back-to-back fills. A miss in the cycle FILL exits is not sampled.
- `write_data_array`, `fill_address`, `fill_data` and `write_tag_array` are combinational from `memory_data_valid` and the counters. The cache arrays capture them on the next edge.

## Structure

- Shared package `cache_pkg` holds:
  - `BLOCK_BYTES = 16` and `WORDS = 8`.
  - The state enum `{IDLE, FILL}`.
  - `OFFSET_BITS = 4`.
- One sub-module is natural: `fill_counter`, an incrementing counter with synchronous clear, saturation and a `done` flag. It is instantiated twice, once for issue and once for receive.

## Test plan

- Reset with all inputs toggling → every output is 0. Release `rst_n` → the block stays in IDLE with `fsm_busy = 0`.
- Miss at `0x1234`, memory model with L=4 → `memory_address` is `0x1230, 0x1232 … 0x123E` in cycles 1..8. `write_data_array` fires in cycles 5..12 with `fill_address` `0x1230 … 0x123E`. `write_tag_array` fires only in cycle 12. `fsm_busy` is high in cycles 0..12.
- Miss at `0xFFFE` → base `0xFFF0`, last address `0xFFFE`, no wrap, eight writes.
- Memory inserts 2 invalid cycles after the 3rd word → writes occur only on valid cycles, `fill_address` stays sequential, and `fsm_busy` extends by 2 cycles.
- `rst_n` asserted after 3 words are written, with the remaining valids still arriving → outputs are 0 at once, there is no tag write, and the late valids are ignored. A new miss at `0x0040` then fills cleanly from `0x0040`.
- `miss_detected` held high throughout → `miss_address` changes during FILL are ignored. After the tag write the block is IDLE for one cycle, then a second fill starts with the new base.
